title_sequencer: RTL
====================

# title_sequencer

Top-level screen sequencer that decides which screen the VGA overlay shows and when gameplay runs. It drives the title-screen overlay enable, the blinking "Press Start" text, a frame-paced fade-out, and the run/pause/game-over phases of the game. Inputs come from the keyboard keycode and game logic. Outputs gate the title address generator, the color mapper and the game-logic reset. All timing is counted in VGA frames, taken from `frame_clk` (vertical sync).

## Interface
Parameters:
- BLINK_FRAMES, 30, frames per half-period of the "Press Start" blink.
- FADE_STEP_FRAMES, 4, frames per brightness decrement during fade-out.
- OVER_HOLD_FRAMES, 180, frames the game-over screen holds before returning to the title screen.

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- frame_clk  input  1  VGA vsync, asynchronous to Clk.
- keycode  input  8  current USB HID keycode; 0x00 when no key is pressed.
- game_over  input  1  level from game logic, meaningful only in GAME.
- state  output  3  encoding: TITLE=0, FADE_OUT=1, GAME=2, PAUSE=3, GAME_OVER=4.
- show_title  output  1  title overlay enable.
- press_start_on  output  1  "Press Start" visible this frame.
- brightness  output  4  color scale; 15 is full, 0 is black.
- game_run  output  1  game logic may advance.
- paused  output  1  pause banner enable.
- game_reset  output  1  single-Clk pulse that reinitialises game logic.

## Operation
Frame tick:
- frame_clk passes through a 2-flop synchronizer, then a rising-edge detect.
- The result is `tick`, one Clk cycle wide, once per frame.

Key presses (press-edge only, so a held key fires once):
- enter = keycode==0x28 and previous-cycle keycode!=0x28.
- esc is the same rule for 0x29.
- pkey is the same rule for 0x13.

States:
- TITLE:
  - show_title=1, brightness=15, game_run=0.
  - The blink counter counts ticks from 0 to BLINK_FRAMES-1. At wrap it returns to 0 and press_start_on toggles.
  - enter → FADE_OUT.
- FADE_OUT:
  - show_title=1 and press_start_on=1 (blink frozen).
  - The step counter counts ticks. On reaching FADE_STEP_FRAMES-1 it returns to 0 and brightness decrements.
  - A step that finds brightness==0 moves to GAME: game_reset=1 that cycle, brightness reloads to 15.
  - Keys are ignored.
- GAME:
  - game_run=1, show_title=0.
  - game_over=1 → GAME_OVER.
  - Otherwise esc → PAUSE.
- PAUSE:
  - game_run=0, paused=1.
  - esc or pkey → GAME (no game_reset).
  - game_over is ignored.
- GAME_OVER:
  - game_run=0.
  - The hold counter counts ticks. At OVER_HOLD_FRAMES-1, or on enter, the state moves to TITLE.
  - On entering TITLE: press_start_on=1, blink counter cleared.

Counter rules:
- Every state entry clears all frame counters.
- Counters are sized ceil(log2(max parameter)).
- Counters never exceed parameter-1.

## Timing
Reset (asynchronous, effective immediately):
- state=TITLE, show_title=1, press_start_on=1, brightness=15.
- game_run=0, paused=0, game_reset=0, all counters 0.
- Reset mid-fade or mid-game returns to these values with no game_reset pulse.

Latency:
- A frame_clk rising edge produces tick 3 Clk edges later.
- All outputs are registered.
- A qualifying tick or key in cycle N shows its state and output change after Clk edge N+1.

Simultaneous events in one cycle:
- game_over beats esc in GAME.
- In GAME_OVER, enter and the hold terminal count are the same transition (taken once).
- In TITLE, enter beats a blink wrap: press_start_on does not toggle that cycle.

Other rules:
- Fade duration from entering FADE_OUT to game_reset is 16×FADE_STEP_FRAMES ticks.
- game_reset is exactly one Clk wide and occurs only on the FADE_OUT→GAME transition.

## Test plan
- Reset, 65 ticks in TITLE → press_start_on toggles at ticks 30 and 60. Ends 1 (on), toggled twice. state=0 throughout.
- Enter held for 10 frames in TITLE → a single FADE_OUT entry. Then:
  - brightness steps 15→0, one step per 4 ticks.
  - game_reset pulses once after 64 ticks.
  - state=2, brightness=15.
- In GAME, esc → state=3, paused=1, game_run=0. Then pkey → state=2, game_reset never asserted.
- In GAME, game_over and esc in the same cycle → state=4. After 180 ticks → state=0, press_start_on=1.
- In GAME_OVER after 50 ticks, enter → state=0 next cycle, blink counter 0.
- Reset asserted mid-FADE_OUT (brightness=7) → immediately state=0, brightness=15, no game_reset pulse.

Source files
------------

// File: rtl/title_sequencer.sv
// Screen sequencer for the title overlay, fade-out and run/pause/game-over phases.
// Frame timing comes from the vsync input, synchronised into the Clk domain.
module title_sequencer #(
    parameter int BLINK_FRAMES     = 30,
    parameter int FADE_STEP_FRAMES = 4,
    parameter int OVER_HOLD_FRAMES = 180
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       game_over,
    output logic [2:0] state,
    output logic       show_title,
    output logic       press_start_on,
    output logic [3:0] brightness,
    output logic       game_run,
    output logic       paused,
    output logic       game_reset
);

    typedef enum logic [2:0] {
        S_TITLE     = 3'd0,
        S_FADE_OUT  = 3'd1,
        S_GAME      = 3'd2,
        S_PAUSE     = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int STEP_W  = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam int HOLD_W  = (OVER_HOLD_FRAMES > 1) ? $clog2(OVER_HOLD_FRAMES) : 1;

    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(FADE_STEP_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(OVER_HOLD_FRAMES - 1);

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_P     = 8'h13;

    state_t cur_state, nxt_state;

    logic [2:0]         fsync;
    logic               tick;
    logic [7:0]         prev_key;
    logic               enter, esc, pkey;

    logic [BLINK_W-1:0] blink_cnt, blink_nxt;
    logic [STEP_W-1:0]  step_cnt, step_nxt;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    logic               pso_nxt, show_nxt, run_nxt, paused_nxt, greset_nxt;
    logic [3:0]         bright_nxt;

    // Two flops for metastability, a third for the rising-edge compare; tick is registered.
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fsync    <= '0;
            tick     <= 1'b0;
            prev_key <= '0;
        end else begin
            fsync    <= {fsync[1:0], frame_clk};
            tick     <= fsync[1] & ~fsync[2];
            prev_key <= keycode;
        end
    end

    assign enter = (keycode == KEY_ENTER) && (prev_key != KEY_ENTER);
    assign esc   = (keycode == KEY_ESC)   && (prev_key != KEY_ESC);
    assign pkey  = (keycode == KEY_P)     && (prev_key != KEY_P);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        nxt_state  = cur_state;
        blink_nxt  = blink_cnt;
        step_nxt   = step_cnt;
        hold_nxt   = hold_cnt;
        pso_nxt    = press_start_on;
        bright_nxt = brightness;
        greset_nxt = 1'b0;

        case (cur_state)
            S_TITLE: begin
                if (enter) begin
                    nxt_state = S_FADE_OUT;
                end else if (tick) begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_nxt = '0;
                        pso_nxt   = ~press_start_on;
                    end else begin
                        blink_nxt = blink_cnt + 1'b1;
                    end
                end
            end
            S_FADE_OUT: begin
                if (tick) begin
                    if (step_cnt == STEP_LAST) begin
                        step_nxt = '0;
                        if (brightness == 4'd0) begin
                            nxt_state  = S_GAME;
                            greset_nxt = 1'b1;
                            bright_nxt = 4'd15;
                        end else begin
                            bright_nxt = brightness - 4'd1;
                        end
                    end else begin
                        step_nxt = step_cnt + 1'b1;
                    end
                end
            end
            S_GAME: begin
                if (game_over)
                    nxt_state = S_GAME_OVER;
                else if (esc)
                    nxt_state = S_PAUSE;
            end
            S_PAUSE: begin
                if (esc || pkey)
                    nxt_state = S_GAME;
            end
            S_GAME_OVER: begin
                if (enter || (tick && hold_cnt == HOLD_LAST))
                    nxt_state = S_TITLE;
                else if (tick)
                    hold_nxt = hold_cnt + 1'b1;
            end
            default: nxt_state = S_TITLE;
        endcase

        // Any state change restarts all frame counters.
        if (nxt_state != cur_state) begin
            blink_nxt = '0;
            step_nxt  = '0;
            hold_nxt  = '0;
            if (nxt_state == S_TITLE) begin
                pso_nxt    = 1'b1;
                bright_nxt = 4'd15;
            end
            if (nxt_state == S_FADE_OUT)
                pso_nxt = 1'b1;
        end

        show_nxt   = (nxt_state == S_TITLE) || (nxt_state == S_FADE_OUT);
        run_nxt    = (nxt_state == S_GAME);
        paused_nxt = (nxt_state == S_PAUSE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cur_state      <= S_TITLE;
            blink_cnt      <= '0;
            step_cnt       <= '0;
            hold_cnt       <= '0;
            show_title     <= 1'b1;
            press_start_on <= 1'b1;
            brightness     <= 4'd15;
            game_run       <= 1'b0;
            paused         <= 1'b0;
            game_reset     <= 1'b0;
        end else begin
            cur_state      <= nxt_state;
            blink_cnt      <= blink_nxt;
            step_cnt       <= step_nxt;
            hold_cnt       <= hold_nxt;
            show_title     <= show_nxt;
            press_start_on <= pso_nxt;
            brightness     <= bright_nxt;
            game_run       <= run_nxt;
            paused         <= paused_nxt;
            game_reset     <= greset_nxt;
        end
    end

    assign state = cur_state;

endmodule
